shift_deserializer: RTL and testbench
=====================================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter SHIFT_WIDTH, default 8, word width in bits (minimum 2).
REQ-002 Parameter SHIFT_DIRECTION, default 1: 1 = MSB first (shift left, new bit into bit 0); 0 = LSB first (shift right, new bit into bit SHIFT_WIDTH-1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 aclr_n  input  1  asynchronous active-low reset.
REQ-005 sclr  input  1  synchronous clear of word assembly, output buffer and flags.
REQ-006 enable  input  1  bit strobe; shiftin is sampled only when high.
REQ-007 shiftin  input  1  serial data bit.
REQ-008 start  input  1  when high with enable, the sampled bit is bit 0 of a new word.
REQ-009 out_ready  input  1  consumer accepts data_out this cycle.
REQ-010 data_out  output  SHIFT_WIDTH  assembled parallel word, registered.
REQ-011 out_valid  output  1  data_out holds an unconsumed word.
REQ-012 overrun  output  1  sticky: a completed word was dropped.
REQ-013 bit_cnt  output  $clog2(SHIFT_WIDTH+1)  bits collected in the current word.

Function
REQ-014 The block SHALL be the receive end of the serial shift link: serial bits in, parallel words out.
REQ-015 FSM SHALL have states IDLE (bit_cnt=0) and SHIFT (0<bit_cnt<SHIFT_WIDTH); IDLE->SHIFT on a sampled bit; SHIFT->IDLE when the SHIFT_WIDTH-th bit is sampled.
REQ-016 Each enable cycle SHALL shift shiftin into the assembly register per SHIFT_DIRECTION and increment bit_cnt.
REQ-017 enable=0 SHALL hold assembly register and bit_cnt unchanged.
REQ-018 start=1 with enable=1 SHALL discard partial bits and restart at bit_cnt=1 with the sampled bit; start without enable SHALL be ignored.
REQ-019 On the edge sampling the SHIFT_WIDTH-th bit, the complete word SHALL reach data_out and out_valid SHALL rise on that same edge (zero added latency), provided the buffer is free.
REQ-020 Buffer free means out_valid=0, or out_valid=1 and out_ready=1 in that cycle.
REQ-021 Handshake: a word is consumed on an edge where out_valid=1 and out_ready=1; out_valid then falls unless a new word loads on the same edge.
REQ-022 data_out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 A word completing while the buffer is not free SHALL be dropped, overrun SHALL set and stay set until sclr or reset; bit_cnt still returns to 0.
REQ-024 sclr SHALL have priority over enable, start and out_ready.
REQ-025 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-026 aclr_n low SHALL immediately force data_out=0, out_valid=0, overrun=0, bit_cnt=0, assembly register=0, state IDLE, regardless of clk.
REQ-027 Reset deassertion mid-word SHALL yield a fresh word beginning with the next sampled bit.
REQ-028 sclr=1 SHALL produce the same values as REQ-026 on the next rising edge.

Structure
REQ-029 Shared package shift_pkg SHALL hold SHIFT_LEFT=1/SHIFT_RIGHT=0 constants and the state enumeration.
REQ-030 Bit counter and word-complete detection SHALL be one sub-module, shift_bit_counter; assembly, buffer and flags stay in the top.

Verification
REQ-031 DIR=1: bits 1,0,1,0,0,1,0,1 with enable=1, out_ready=1 -> data_out=0xA5, out_valid=1 for one cycle after 8th edge, overrun=0.
REQ-032 DIR=0: bits 1,0,1,0,0,1,0,1 -> data_out=0xA5; enable toggled between bits -> same result, bit_cnt holds during gaps.
REQ-033 out_ready=0, send 0x3C then 0xC3 -> data_out stays 0x3C, overrun=1; then out_ready=1 -> out_valid falls, overrun stays 1 until sclr.
REQ-034 Word 0x3C held, 0xC3 completes on the edge with out_ready=1 -> data_out=0xC3, out_valid stays 1, overrun=0.
REQ-035 Three bits then start=1 with 8 bits of 0x81 -> data_out=0x81, partial bits discarded.
REQ-036 aclr_n low mid-word (bit_cnt=4) and sclr=1 with out_valid=1 -> all outputs 0; next 8 bits of 0x5A -> data_out=0x5A.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants and FSM state type for the serial shift link
package shift_pkg;

    localparam int SHIFT_LEFT  = 1;
    localparam int SHIFT_RIGHT = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - bit counter FSM and word-complete detection
module shift_bit_counter
    import shift_pkg::*;
#(
    parameter int SHIFT_WIDTH = 8,
    localparam int CW = $clog2(SHIFT_WIDTH + 1)
) (
    input  logic          clk,
    input  logic          aclr_n,
    input  logic          sclr,
    input  logic          enable,
    input  logic          start,
    output logic [CW-1:0] bit_cnt,
    output logic          word_done
);

    localparam logic [CW-1:0] LAST = CW'(SHIFT_WIDTH - 1);

    shift_state_t state;

    // The sampled bit is the last one of the word; a start bit always opens a new word instead.
    assign word_done = enable && !start && (state == ST_SHIFT) && (bit_cnt == LAST);

    // Count sampled bits; restart on start, wrap to IDLE on the final bit.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else if (sclr) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else if (enable) begin
            if (start) begin
                state   <= ST_SHIFT;
                bit_cnt <= CW'(1);
            end else if (word_done) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else begin
                state   <= ST_SHIFT;
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - serial-to-parallel receiver with one-word output buffer
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int SHIFT_WIDTH     = 8,
    parameter int SHIFT_DIRECTION = SHIFT_LEFT
) (
    input  logic                               clk,
    input  logic                               aclr_n,
    input  logic                               sclr,
    input  logic                               enable,
    input  logic                               shiftin,
    input  logic                               start,
    input  logic                               out_ready,
    output logic [SHIFT_WIDTH-1:0]             data_out,
    output logic                               out_valid,
    output logic                               overrun,
    output logic [$clog2(SHIFT_WIDTH+1)-1:0]   bit_cnt
);

    localparam bit MSB_FIRST = (SHIFT_DIRECTION != SHIFT_RIGHT);

    logic [SHIFT_WIDTH-1:0] asm_q;
    logic [SHIFT_WIDTH-1:0] asm_base;
    logic [SHIFT_WIDTH-1:0] asm_next;
    logic                   word_done;
    logic                   buf_free;

    shift_bit_counter #(
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_bit_counter (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .sclr      (sclr),
        .enable    (enable),
        .start     (start),
        .bit_cnt   (bit_cnt),
        .word_done (word_done)
    );

    // Next assembly value; a start bit discards any partial word before shifting.
    always_comb begin
        asm_base = start ? '0 : asm_q;
        if (MSB_FIRST) begin
            asm_next = {asm_base[SHIFT_WIDTH-2:0], shiftin};
        end else begin
            asm_next = {shiftin, asm_base[SHIFT_WIDTH-1:1]};
        end
    end

    // The buffer can take a word if empty or being drained on this same edge.
    assign buf_free = !out_valid || out_ready;

    // Assembly register; cleared once a word completes so the next word starts clean.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            asm_q <= '0;
        end else if (sclr) begin
            asm_q <= '0;
        end else if (enable) begin
            asm_q <= word_done ? '0 : asm_next;
        end
    end

    // Output buffer, handshake and sticky overrun; a completed word bypasses asm_q for zero latency.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (sclr) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (word_done && buf_free) begin
                data_out  <= asm_next;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (word_done && !buf_free) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// tb/tb_shift_deserializer.sv - scoreboard bench for MSB-first and LSB-first deserializers
module tb_shift_deserializer;

    logic       clk = 1'b0;
    logic       aclr_n;
    logic       sclr;
    logic       enable;
    logic       shiftin;
    logic       start;
    logic       out_ready;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;
    logic [3:0] m_cnt;
    logic [7:0] l_data;
    logic       l_valid;
    logic       l_ovr;
    logic [3:0] l_cnt;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    logic       m_pending = 1'b0;
    logic       l_pending = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_deserializer #(.SHIFT_WIDTH(8), .SHIFT_DIRECTION(1)) dut_msb (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .sclr      (sclr),
        .enable    (enable),
        .shiftin   (shiftin),
        .start     (start),
        .out_ready (out_ready),
        .data_out  (m_data),
        .out_valid (m_valid),
        .overrun   (m_ovr),
        .bit_cnt   (m_cnt)
    );

    shift_deserializer #(.SHIFT_WIDTH(8), .SHIFT_DIRECTION(0)) dut_lsb (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .sclr      (sclr),
        .enable    (enable),
        .shiftin   (shiftin),
        .start     (start),
        .out_ready (out_ready),
        .data_out  (l_data),
        .out_valid (l_valid),
        .overrun   (l_ovr),
        .bit_cnt   (l_cnt)
    );

    // MSB-first monitor: each newly presented word is popped and compared once.
    always @(negedge clk) begin
        if (m_valid && !m_pending) begin
            checks++;
            if (q_m.size() == 0) begin
                errors++;
                $display("FAIL msb_word: unexpected data_out=%h, nothing expected", m_data);
            end else begin
                if (m_data !== q_m[0]) begin
                    errors++;
                    $display("FAIL msb_word: data_out=%h expected=%h", m_data, q_m[0]);
                end
                void'(q_m.pop_front());
            end
        end
        m_pending <= m_valid && !out_ready;
    end

    // LSB-first monitor.
    always @(negedge clk) begin
        if (l_valid && !l_pending) begin
            checks++;
            if (q_l.size() == 0) begin
                errors++;
                $display("FAIL lsb_word: unexpected data_out=%h, nothing expected", l_data);
            end else begin
                if (l_data !== q_l[0]) begin
                    errors++;
                    $display("FAIL lsb_word: data_out=%h expected=%h", l_data, q_l[0]);
                end
                void'(q_l.pop_front());
            end
        end
        l_pending <= l_valid && !out_ready;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bits go out w[7] first; the LSB-first DUT therefore assembles bit-reversed w.
    task automatic send_bits(input logic [7:0] w, input int n, input bit gap, input bit first_start);
        for (int i = 0; i < n; i++) begin
            enable  = 1'b1;
            shiftin = w[7-i];
            start   = (i == 0) && first_start;
            tick();
            enable  = 1'b0;
            start   = 1'b0;
            if (gap) begin
                tick();
                chk("gap_hold_msb_cnt", 32'(m_cnt), 32'((i + 1) % 8));
                chk("gap_hold_lsb_cnt", 32'(l_cnt), 32'((i + 1) % 8));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        aclr_n = 1'b0; sclr = 1'b0; enable = 1'b0; shiftin = 1'b0;
        start = 1'b0; out_ready = 1'b0;
        #3;
        chk("reset_data",  32'(m_data),  32'h0);
        chk("reset_valid", 32'(m_valid), 32'h0);
        chk("reset_ovr",   32'(m_ovr),   32'h0);
        chk("reset_cnt",   32'(m_cnt),   32'h0);
        repeat (2) @(posedge clk);
        #1 aclr_n = 1'b1;
        tick();

        // Basic word, both directions, consumer always ready.
        out_ready = 1'b1;
        q_m.push_back(8'hA5); q_l.push_back(8'hA5);
        send_bits(8'hA5, 8, 1'b0, 1'b0);
        chk("a5_valid",    32'(m_valid), 32'h1);
        chk("a5_data_msb", 32'(m_data),  32'hA5);
        chk("a5_data_lsb", 32'(l_data),  32'hA5);
        chk("a5_ovr",      32'(m_ovr),   32'h0);
        chk("a5_cnt",      32'(m_cnt),   32'h0);
        tick();
        chk("a5_valid_one_cycle", 32'(m_valid), 32'h0);

        // Gapped enable, non-symmetric word: 0x12 MSB-first, reversed 0x48 LSB-first.
        q_m.push_back(8'h12); q_l.push_back(8'h48);
        send_bits(8'h12, 8, 1'b1, 1'b0);
        chk("gap_data_lsb", 32'(l_data), 32'h48);

        // Overrun: second word dropped while first is held.
        out_ready = 1'b0;
        q_m.push_back(8'h3C); q_l.push_back(8'h3C);
        send_bits(8'h3C, 8, 1'b0, 1'b0);
        send_bits(8'hC3, 8, 1'b0, 1'b0);
        chk("ovr_hold_data", 32'(m_data),  32'h3C);
        chk("ovr_valid",     32'(m_valid), 32'h1);
        chk("ovr_set_msb",   32'(m_ovr),   32'h1);
        chk("ovr_set_lsb",   32'(l_ovr),   32'h1);
        out_ready = 1'b1;
        tick();
        chk("ovr_drain_valid", 32'(m_valid), 32'h0);
        chk("ovr_sticky",      32'(m_ovr),   32'h1);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        chk("ovr_sclr", 32'(m_ovr), 32'h0);

        // Word completes on the same edge the held word is consumed.
        out_ready = 1'b0;
        q_m.push_back(8'h3C); q_l.push_back(8'h3C);
        send_bits(8'h3C, 8, 1'b0, 1'b0);
        q_m.push_back(8'hC3); q_l.push_back(8'hC3);
        send_bits(8'hC3, 7, 1'b0, 1'b0);
        out_ready = 1'b1;
        send_bits(8'h80, 1, 1'b0, 1'b0);
        chk("bb_data",  32'(m_data),  32'hC3);
        chk("bb_valid", 32'(m_valid), 32'h1);
        chk("bb_ovr",   32'(m_ovr),   32'h0);
        tick();
        chk("bb_drain", 32'(m_valid), 32'h0);

        // Start discards partial bits.
        send_bits(8'hE0, 3, 1'b0, 1'b0);
        chk("partial_cnt", 32'(m_cnt), 32'h3);
        q_m.push_back(8'h81); q_l.push_back(8'h81);
        send_bits(8'h81, 8, 1'b0, 1'b1);
        chk("start_data", 32'(m_data), 32'h81);
        tick();

        // Asynchronous reset mid-word.
        send_bits(8'hF0, 4, 1'b0, 1'b0);
        chk("mid_cnt", 32'(m_cnt), 32'h4);
        #2 aclr_n = 1'b0;
        #1;
        chk("areset_data",  32'(m_data),  32'h0);
        chk("areset_valid", 32'(m_valid), 32'h0);
        chk("areset_cnt",   32'(m_cnt),   32'h0);
        chk("areset_ldata", 32'(l_data),  32'h0);
        #1 aclr_n = 1'b1;
        tick();
        q_m.push_back(8'h5A); q_l.push_back(8'h5A);
        send_bits(8'h5A, 8, 1'b0, 1'b0);
        chk("post_reset_data", 32'(m_data), 32'h5A);
        tick();

        // Synchronous clear while a word is held and another is partial.
        out_ready = 1'b0;
        q_m.push_back(8'h12); q_l.push_back(8'h48);
        send_bits(8'h12, 8, 1'b0, 1'b0);
        chk("held_valid", 32'(m_valid), 32'h1);
        send_bits(8'hFF, 3, 1'b0, 1'b0);
        sclr   = 1'b1;
        enable = 1'b1;
        shiftin = 1'b1;
        tick();
        sclr   = 1'b0;
        enable = 1'b0;
        chk("sclr_data",  32'(m_data),  32'h0);
        chk("sclr_valid", 32'(m_valid), 32'h0);
        chk("sclr_cnt",   32'(m_cnt),   32'h0);
        chk("sclr_ovr",   32'(m_ovr),   32'h0);
        chk("sclr_lcnt",  32'(l_cnt),   32'h0);
        out_ready = 1'b1;
        q_m.push_back(8'h5A); q_l.push_back(8'h5A);
        send_bits(8'h5A, 8, 1'b0, 1'b0);
        chk("post_sclr_data", 32'(m_data), 32'h5A);
        tick();
        tick();

        chk("msb_queue_empty", 32'(q_m.size()), 32'h0);
        chk("lsb_queue_empty", 32'(q_l.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
